// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic FETCH    = 1'b0;
    localparam logic DATA     = 1'b1;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Winner of an IDLE-cycle arbitration; on conflict the previous loser goes.
    function automatic logic pick_owner(
        input logic if_req,
        input logic dm_req,
        input logic last_win
    );
        logic owner;
        if (if_req && dm_req) begin
            owner = ~last_win;
        end else if (dm_req) begin
            owner = DATA;
        end else begin
            owner = FETCH;
        end
        return owner;
    endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter timing the RAM access phase; done when it reaches zero.
module lat_counter #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data RAM sequencer shared by instruction fetch and the LDR/STR stage.
// One transaction at a time: IDLE arbitrates, ACCESS drives the RAM, RESP returns.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_rw,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              ram_en,
    output logic              RW,
    output logic [ADDR_W-1:0] address_out,
    output logic [DATA_W-1:0] RAM_in,
    input  logic [DATA_W-1:0] RAM_out,
    output logic              stall
);

    localparam int unsigned CNT_W = $clog2(RAM_LAT + 1);

    state_e            state_q,    state_d;
    logic              owner_q,    owner_d;
    logic              last_win_q, last_win_d;
    logic              if_gnt_q,   if_gnt_d;
    logic              dm_gnt_q,   dm_gnt_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic              ram_en_q,   ram_en_d;
    logic              rw_q,       rw_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] ram_in_q,   ram_in_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic              grant_owner;
    logic              grant_rw;
    logic              lat_load;
    logic [CNT_W-1:0]  lat_load_val;
    logic              lat_dec;
    logic              lat_done;

    lat_counter #(
        .W (CNT_W)
    ) u_lat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lat_load),
        .load_val (lat_load_val),
        .dec      (lat_dec),
        .done     (lat_done)
    );

    // Arbitration result, only consumed in IDLE.
    always_comb begin
        grant_owner = pick_owner(if_req, dm_req, last_win_q);
        grant_rw    = (grant_owner == DATA) ? dm_rw : RW_READ;
    end

    // Next-state and next-output logic; RAM lines are zero outside ACCESS.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_win_d   = last_win_q;
        if_gnt_d     = 1'b0;
        dm_gnt_d     = 1'b0;
        if_valid_d   = 1'b0;
        dm_valid_d   = 1'b0;
        ram_en_d     = 1'b0;
        rw_d         = 1'b0;
        addr_d       = '0;
        ram_in_d     = '0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        lat_load     = 1'b0;
        lat_load_val = '0;
        lat_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_d      = ACCESS;
                    owner_d      = grant_owner;
                    last_win_d   = grant_owner;
                    if_gnt_d     = (grant_owner == FETCH);
                    dm_gnt_d     = (grant_owner == DATA);
                    ram_en_d     = 1'b1;
                    rw_d         = grant_rw;
                    addr_d       = (grant_owner == DATA) ? dm_addr : if_addr;
                    ram_in_d     = (grant_rw == RW_WRITE) ? dm_wdata : '0;
                    lat_load     = 1'b1;
                    lat_load_val = (grant_rw == RW_READ) ? CNT_W'(RAM_LAT - 1) : '0;
                end
            end
            ACCESS: begin
                if (lat_done) begin
                    state_d    = RESP;
                    if_valid_d = (owner_q == FETCH);
                    dm_valid_d = (owner_q == DATA);
                    if (rw_q == RW_READ) begin
                        if (owner_q == FETCH) begin
                            if_rdata_d = RAM_out;
                        end else begin
                            dm_rdata_d = RAM_out;
                        end
                    end
                end else begin
                    lat_dec  = 1'b1;
                    ram_en_d = 1'b1;
                    rw_d     = rw_q;
                    addr_d   = addr_q;
                    ram_in_d = ram_in_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= FETCH;
            last_win_q <= FETCH;
            if_gnt_q   <= 1'b0;
            dm_gnt_q   <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            ram_en_q   <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            ram_in_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_win_q <= last_win_d;
            if_gnt_q   <= if_gnt_d;
            dm_gnt_q   <= dm_gnt_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            ram_en_q   <= ram_en_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            ram_in_q   <= ram_in_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign if_gnt      = if_gnt_q;
    assign dm_gnt      = dm_gnt_q;
    assign if_valid    = if_valid_q;
    assign dm_valid    = dm_valid_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign ram_en      = ram_en_q;
    assign RW          = rw_q;
    assign address_out = addr_q;
    assign RAM_in      = ram_in_q;

    // Stall while any requester is still waiting on its response.
    assign stall = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: transaction-timing model of the arbiter plus directed literal checks.
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 2;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_rw;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_valid;
    logic [DW-1:0] dm_rdata;
    logic          ram_en;
    logic          rw_o;
    logic [AW-1:0] address_out;
    logic [DW-1:0] ram_in;
    logic [DW-1:0] ram_out;
    logic          stall;

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RAM_LAT (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_valid    (if_valid),
        .if_rdata    (if_rdata),
        .dm_req      (dm_req),
        .dm_rw       (dm_rw),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_gnt      (dm_gnt),
        .dm_valid    (dm_valid),
        .dm_rdata    (dm_rdata),
        .ram_en      (ram_en),
        .RW          (rw_o),
        .address_out (address_out),
        .RAM_in      (ram_in),
        .RAM_out     (ram_out),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: a transaction granted in idle cycle c occupies the RAM for
    // cycles c+1 .. c+len (len = LAT for reads, 1 for writes), returns at c+len+1,
    // and the port is idle again from c+len+2.
    bit            m_ok = 1'b0;
    bit            m_busy;
    bit            m_own;
    bit            m_rw;
    bit            m_last;
    int            m_s;
    int            m_len;
    int            m_cyc = 0;
    int            m_k;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rd_if;
    logic [DW-1:0] m_rd_dm;
    bit            e_acc;
    bit            e_rsp;
    bit            e_ifv;
    bit            e_dmv;
    bit            m_win;

    always @(negedge clk) begin
        m_k   = m_busy ? (m_cyc - m_s) : -1;
        e_acc = m_busy && (m_k >= 0) && (m_k < m_len);
        e_rsp = m_busy && (m_k == m_len);
        e_ifv = e_rsp && (m_own == 1'b0);
        e_dmv = e_rsp && (m_own == 1'b1);
        if (m_ok) begin
            chk("ram_en", 64'(ram_en), 64'(e_acc));
            chk("RW", 64'(rw_o), e_acc ? 64'(m_rw) : 64'd0);
            chk("address_out", 64'(address_out), e_acc ? 64'(m_addr) : 64'd0);
            chk("RAM_in", 64'(ram_in), (e_acc && !m_rw) ? 64'(m_wdata) : 64'd0);
            chk("if_gnt", 64'(if_gnt), 64'(e_acc && m_k == 0 && m_own == 1'b0));
            chk("dm_gnt", 64'(dm_gnt), 64'(e_acc && m_k == 0 && m_own == 1'b1));
            chk("if_valid", 64'(if_valid), 64'(e_ifv));
            chk("dm_valid", 64'(dm_valid), 64'(e_dmv));
            chk("if_rdata", 64'(if_rdata), 64'(m_rd_if));
            chk("dm_rdata", 64'(dm_rdata), 64'(m_rd_dm));
            chk("stall", 64'(stall), 64'((if_req && !e_ifv) || (dm_req && !e_dmv)));
        end
        if (!rst_n) begin
            m_ok    = 1'b1;
            m_busy  = 1'b0;
            m_last  = 1'b0;
            m_rd_if = '0;
            m_rd_dm = '0;
        end else if (m_ok) begin
            if (m_busy && (m_k == m_len - 1) && m_rw) begin
                if (m_own) m_rd_dm = ram_out;
                else       m_rd_if = ram_out;
            end
            if ((!m_busy || m_k > m_len) && (if_req || dm_req)) begin
                m_win   = (if_req && dm_req) ? !m_last : dm_req;
                m_last  = m_win;
                m_own   = m_win;
                m_rw    = m_win ? dm_rw : 1'b1;
                m_addr  = m_win ? dm_addr : if_addr;
                m_wdata = dm_wdata;
                m_len   = m_rw ? int'(LAT) : 1;
                m_s     = m_cyc + 1;
                m_busy  = 1'b1;
            end
        end
        m_cyc++;
    end

    int g1;
    int g2;
    int n_gnt;
    int order;

    initial begin
        rst_n    = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_rw    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        ram_out  = '0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_ram_en", 64'(ram_en), 64'd0);
        chk("reset_if_rdata", 64'(if_rdata), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Lone fetch
        if_req  = 1'b1;
        if_addr = 32'h10;
        ram_out = 32'hDEADBEEF;
        step();
        @(negedge clk);
        chk("fetch_gnt", 64'(if_gnt), 64'd1);
        chk("fetch_addr", 64'(address_out), 64'h10);
        chk("fetch_rw", 64'(rw_o), 64'd1);
        step();
        step();
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch_valid", 64'(if_valid), 64'd1);
        chk("fetch_rdata", 64'(if_rdata), 64'hDEADBEEF);
        step();

        // Store
        dm_req   = 1'b1;
        dm_rw    = 1'b0;
        dm_addr  = 32'h40;
        dm_wdata = 32'h1234;
        step();
        @(negedge clk);
        chk("store_ram_en", 64'(ram_en), 64'd1);
        chk("store_rw", 64'(rw_o), 64'd0);
        chk("store_ram_in", 64'(ram_in), 64'h1234);
        step();
        dm_req = 1'b0;
        @(negedge clk);
        chk("store_valid", 64'(dm_valid), 64'd1);
        chk("store_if_valid", 64'(if_valid), 64'd0);
        step();

        // Load stall window
        dm_req  = 1'b1;
        dm_rw   = 1'b1;
        dm_addr = 32'h80;
        ram_out = 32'hCAFE0001;
        @(negedge clk);
        chk("stall_n0", 64'(stall), 64'd1);
        step();
        @(negedge clk);
        chk("stall_n1", 64'(stall), 64'd1);
        step();
        @(negedge clk);
        chk("stall_n2", 64'(stall), 64'd1);
        step();
        dm_req = 1'b0;
        @(negedge clk);
        chk("load_valid", 64'(dm_valid), 64'd1);
        chk("load_rdata", 64'(dm_rdata), 64'hCAFE0001);
        chk("stall_valid", 64'(stall), 64'd0);
        step();
        @(negedge clk);
        chk("stall_after", 64'(stall), 64'd0);
        step();

        // Back-to-back fetches
        if_req  = 1'b1;
        if_addr = 32'h20;
        g1 = -1;
        g2 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_gnt) begin
                if (g1 < 0) g1 = i;
                else if (g2 < 0) g2 = i;
            end
            if (g2 >= 0 && if_valid) break;
            step();
        end
        step();
        if_req = 1'b0;
        chk("b2b_spacing", 64'(g2 - g1), 64'(LAT + 2));
        step();

        // Conflict fairness from reset
        rst_n   = 1'b0;
        if_req  = 1'b1;
        dm_req  = 1'b1;
        dm_rw   = 1'b1;
        if_addr = 32'h100;
        dm_addr = 32'h200;
        step();
        step();
        rst_n = 1'b1;
        n_gnt = 0;
        order = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_gnt) begin
                n_gnt++;
                order = order * 2;
            end
            if (dm_gnt) begin
                n_gnt++;
                order = order * 2 + 1;
            end
            if (n_gnt >= 3 && (if_valid || dm_valid)) break;
            step();
        end
        step();
        if_req = 1'b0;
        dm_req = 1'b0;
        chk("fair_count", 64'(n_gnt), 64'd3);
        chk("fair_order", 64'(order), 64'b101);
        step();
        step();

        // Reset during the second ACCESS cycle of a read
        if_req  = 1'b1;
        if_addr = 32'h30;
        ram_out = 32'h5555AAAA;
        step();
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_access_en", 64'(ram_en), 64'd1);
        step();
        rst_n  = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_ram_en", 64'(ram_en), 64'd0);
        chk("mid_rst_valid", 64'(if_valid), 64'd0);
        chk("mid_rst_rdata", 64'(if_rdata), 64'd0);
        step();
        @(negedge clk);
        chk("mid_rst_valid2", 64'(if_valid), 64'd0);
        step();
        dm_req   = 1'b1;
        dm_rw    = 1'b0;
        dm_addr  = 32'h44;
        dm_wdata = 32'h77;
        step();
        @(negedge clk);
        chk("post_rst_gnt", 64'(dm_gnt), 64'd1);
        step();
        dm_req = 1'b0;
        step();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            step();
            ram_out = $urandom;
            rst_n   = ($urandom_range(0, 149) != 0);
            if (!if_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    if_req  = 1'b1;
                    if_addr = $urandom;
                end
            end else if (if_valid) begin
                if ($urandom_range(0, 1) == 0) if_req = 1'b0;
                else if_addr = $urandom;
            end
            if (!dm_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    dm_req   = 1'b1;
                    dm_rw    = 1'($urandom_range(0, 1));
                    dm_addr  = $urandom;
                    dm_wdata = $urandom;
                end
            end else if (dm_valid) begin
                if ($urandom_range(0, 1) == 0) begin
                    dm_req = 1'b0;
                end else begin
                    dm_rw    = 1'($urandom_range(0, 1));
                    dm_addr  = $urandom;
                    dm_wdata = $urandom;
                end
            end
        end
        step();
        rst_n  = 1'b1;
        if_req = 1'b0;
        dm_req = 1'b0;
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
